// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// Package: mem_ctrl_pkg
// Purpose: Shared definitions for the MEM-stage data-memory controller:
//          FSM state encoding, access-size codes, the default wait timeout
//          and the alignment helper used when ALIGN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is handled as a word too

  localparam int DEFAULT_TIMEOUT = 15;

  // Halfwords need addr[0]==0; words (and size 11) need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF)
      mis = addr_lo[0];
    else if (size[1])
      mis = |addr_lo;
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// Module: load_extend
// Purpose: Combinational size/sign extender for load data.
//          Byte takes rdata[7:0], half takes rdata[15:0]; each is sign- or
//          zero-extended by se. Word (and size 11) passes rdata unchanged.
// Ports:
//   rdata  in   DATA_W  raw read data from the data memory
//   size   in   2       access size code (SZ_BYTE / SZ_HALF / SZ_WORD)
//   se     in   1       1 = sign-extend, 0 = zero-extend
//   data   out  DATA_W  extended result
// -----------------------------------------------------------------------------
module load_extend
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              se,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    data = rdata;
    case (size)
      SZ_BYTE: data = se ? {{(DATA_W-8){rdata[7]}}, rdata[7:0]}
                         : {{(DATA_W-8){1'b0}},     rdata[7:0]};
      SZ_HALF: data = se ? {{(DATA_W-16){rdata[15]}}, rdata[15:0]}
                         : {{(DATA_W-16){1'b0}},      rdata[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// Module: mem_stage_ctrl
// Purpose: MEM-stage sequencer. Latches the EX/MEM access fields, drives a
//          variable-latency data-memory port with a req/ready handshake,
//          stalls the pipeline until the access completes, and returns
//          size/sign-extended load data. A request that waits TIMEOUT ACCESS
//          cycles without dm_ready is abandoned and raises a sticky bus_error.
// Configuration macro: ALIGN_CHECK_EN
//   defined   -> adds output align_fault; misaligned half/word accesses skip
//                the memory (IDLE -> DONE) and pulse align_fault in DONE.
//   undefined -> no alignment check, the address is issued unaltered.
// Ports:
//   clk, reset (async, active high)
//   mem_enable/mem_rw/mem_size/mem_se/mem_addr/mem_wdata   EX/MEM fields
//   dm_req/dm_rw/dm_size/dm_addr/dm_wdata (out), dm_ready/dm_rdata (in)
//   stall       freeze PC, IF/ID, ID/EX, EX/MEM
//   load_data   extended load result; load_valid 1-cycle pulse for loads
//   bus_error   sticky timeout flag
//   align_fault (ALIGN_CHECK_EN only) 1-cycle misalignment pulse
// -----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_se,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              dm_req,
  output logic              dm_rw,
  output logic [1:0]        dm_size,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ready,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              bus_error
`ifdef ALIGN_CHECK_EN
  ,
  output logic              align_fault
`endif
);

  state_t            state, next_state;
  logic [TO_W-1:0]   wait_cnt;
  logic              lat_se;
  logic              lat_misalign;
  logic              misalign_in;
  logic              timeout_hit;
  logic [DATA_W-1:0] ext_data;

`ifdef ALIGN_CHECK_EN
  assign misalign_in = is_misaligned(mem_size, mem_addr[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  // wait_cnt counts the ACCESS cycles already spent without dm_ready, so the
  // TIMEOUT-th such cycle is the one where it reads TIMEOUT-1.
  assign timeout_hit = !dm_ready && (wait_cnt == TO_W'(TIMEOUT - 1));

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata (dm_rdata),
    .size  (dm_size),
    .se    (lat_se),
    .data  (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // dm_req, stall and load_valid decode the state directly, so an
  // asynchronous reset drops them immediately, even mid-access.
  always_comb begin
    next_state = state;
    dm_req     = 1'b0;
    stall      = 1'b0;
    load_valid = 1'b0;
`ifdef ALIGN_CHECK_EN
    align_fault = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (mem_enable) begin
          stall      = 1'b1;
          next_state = misalign_in ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        dm_req = 1'b1;
        stall  = 1'b1;
        if (dm_ready || timeout_hit) next_state = DONE;
      end
      DONE: begin
        load_valid = !dm_rw && !lat_misalign;
`ifdef ALIGN_CHECK_EN
        align_fault = lat_misalign;
`endif
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_rw        <= 1'b0;
      dm_size      <= 2'b00;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      lat_se       <= 1'b0;
      lat_misalign <= 1'b0;
      wait_cnt     <= '0;
      load_data    <= '0;
      bus_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are captured once here; input changes while stalled
          // are ignored.
          if (mem_enable) begin
            dm_rw        <= mem_rw;
            dm_size      <= mem_size;
            dm_addr      <= mem_addr;
            dm_wdata     <= mem_wdata;
            lat_se       <= mem_se;
            lat_misalign <= misalign_in;
          end
        end
        ACCESS: begin
          if (dm_ready) begin
            if (!dm_rw) load_data <= ext_data;
          end else if (timeout_hit) begin
            bus_error <= 1'b1;
            if (!dm_rw) load_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: wait_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench: tb_mem_stage_ctrl
// Directed vectors for mem_stage_ctrl with hand-computed expectations:
// reset state, load extension cases, delayed store, timeout, reset in
// mid-access, and the alignment behaviour of the current build.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_enable;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic              mem_se;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              dm_req;
  logic              dm_rw;
  logic [1:0]        dm_size;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;
  logic              stall;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              bus_error;
`ifdef ALIGN_CHECK_EN
  logic              align_fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT(15), .TO_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_enable (mem_enable),
    .mem_rw     (mem_rw),
    .mem_size   (mem_size),
    .mem_se     (mem_se),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .dm_req     (dm_req),
    .dm_rw      (dm_rw),
    .dm_size    (dm_size),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ready   (dm_ready),
    .dm_rdata   (dm_rdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .bus_error  (bus_error)
`ifdef ALIGN_CHECK_EN
    ,
    .align_fault(align_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load with dm_ready in the first ACCESS cycle.
  task automatic run_load(input string tag, input logic [1:0] size,
                          input logic se, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    mem_enable = 1'b1; mem_rw = 1'b0; mem_size = size; mem_se = se;
    mem_addr = addr; mem_wdata = '0;
    #1 check({tag, " stall_idle"}, stall, 1);
    tick();                                   // now in ACCESS
    mem_enable = 1'b0; mem_addr = 32'hFFFF_FFFF; mem_size = ~size;
    check({tag, " dm_req"}, dm_req, 1);
    check({tag, " dm_addr"}, dm_addr, addr);
    check({tag, " stall_acc"}, stall, 1);
    dm_ready = 1'b1; dm_rdata = rdata;
    tick();                                   // now in DONE
    dm_ready = 1'b0; dm_rdata = 32'h5A5A_5A5A;
    check({tag, " load_valid"}, load_valid, 1);
    check({tag, " load_data"}, load_data, exp);
    check({tag, " stall_done"}, stall, 0);
    check({tag, " req_done"}, dm_req, 0);
    tick();                                   // back in IDLE
    check({tag, " lv_pulse"}, load_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    int acc_cycles;
    logic lv_seen;

    reset = 1'b1; mem_enable = 1'b0; mem_rw = 1'b0; mem_size = 2'b00;
    mem_se = 1'b0; mem_addr = '0; mem_wdata = '0; dm_ready = 1'b0;
    dm_rdata = '0;
    tick(); tick();
    check("rst dm_req", dm_req, 0);
    check("rst stall", stall, 0);
    check("rst load_valid", load_valid, 0);
    check("rst load_data", load_data, 0);
    check("rst bus_error", bus_error, 0);
    check("rst dm_addr", dm_addr, 0);
    reset = 1'b0;
    tick();
    // dm_ready outside ACCESS must not start anything.
    dm_ready = 1'b1; dm_rdata = 32'h1234_5678;
    tick();
    check("idle ready ignored", load_data, 0);
    check("idle no req", dm_req, 0);
    dm_ready = 1'b0;

    // Load extension cases.
    run_load("lw",      2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb se",   2'b00, 1'b1, 32'h21, 32'h0000_0080, 32'hFFFF_FF80);
    run_load("lb ze",   2'b00, 1'b0, 32'h22, 32'h0000_0080, 32'h0000_0080);
    run_load("lh se",   2'b01, 1'b1, 32'h24, 32'h0000_8001, 32'hFFFF_8001);
    run_load("lh ze",   2'b01, 1'b0, 32'h26, 32'hFFFF_8001, 32'h0000_8001);
    run_load("lb pos",  2'b00, 1'b1, 32'h27, 32'hABCD_EF7F, 32'h0000_007F);
    run_load("size11",  2'b11, 1'b1, 32'h28, 32'h8765_4321, 32'h8765_4321);

    // Store with dm_ready delayed 4 cycles.
    mem_enable = 1'b1; mem_rw = 1'b1; mem_size = 2'b10; mem_se = 1'b0;
    mem_addr = 32'h44; mem_wdata = 32'hCAFE_F00D;
    tick();
    mem_enable = 1'b0; mem_addr = '0; mem_wdata = '0;
    req_cycles = 0; lv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dm_req) req_cycles++;
      lv_seen |= load_valid;
      check("st dm_addr", dm_addr, 32'h44);
      check("st dm_wdata", dm_wdata, 32'hCAFE_F00D);
      tick();
    end
    dm_ready = 1'b1;
    if (dm_req) req_cycles++;
    check("st dm_rw", dm_rw, 1);
    tick();
    dm_ready = 1'b0;
    lv_seen |= load_valid;
    check("st load_data held", load_data, 32'h8765_4321);
    check("st req cycles", req_cycles, 5);
    tick();
    lv_seen |= load_valid;
    check("st load_valid never", lv_seen, 0);

    // Timeout: no dm_ready at all.
    mem_enable = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 32'h80;
    tick();
    mem_enable = 1'b0;
    acc_cycles = 0;
    while (dm_req && acc_cycles < 40) begin
      acc_cycles++;
      tick();
    end
    check("to access cycles", acc_cycles, 15);
    check("to bus_error", bus_error, 1);
    check("to load_data", load_data, 0);
    tick();
    check("to idle req", dm_req, 0);
    check("to idle stall", stall, 0);
    run_load("after to", 2'b10, 1'b0, 32'h84, 32'h0BAD_F00D, 32'h0BAD_F00D);
    check("to sticky", bus_error, 1);

    // Reset in the second ACCESS cycle.
    mem_enable = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 32'h20;
    tick();
    mem_enable = 1'b0;
    tick();
    check("rstacc req before", dm_req, 1);
    reset = 1'b1;
    #1;
    check("rstacc dm_req", dm_req, 0);
    check("rstacc stall", stall, 0);
    check("rstacc bus_error", bus_error, 0);
    tick();
    reset = 1'b0;
    tick();
    run_load("post rst", 2'b01, 1'b1, 32'h30, 32'h1234_F00F, 32'hFFFF_F00F);

`ifdef ALIGN_CHECK_EN
    // Misaligned word load skips the memory.
    mem_enable = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 32'h2;
    #1 check("al stall idle", stall, 1);
    tick();
    mem_enable = 1'b0;
    check("al dm_req", dm_req, 0);
    check("al fault", align_fault, 1);
    check("al load_valid", load_valid, 0);
    check("al stall done", stall, 0);
    tick();
    check("al fault pulse", align_fault, 0);
    run_load("al ok half", 2'b01, 1'b0, 32'h2, 32'h0000_9999, 32'h0000_9999);
`else
    // Without the check a misaligned word is issued unaltered.
    run_load("unaligned", 2'b10, 1'b0, 32'h2, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
